// File: rtl/uart_pkg.sv
// Shared UART types and defaults.
// Holds the RX FIFO word layout and the default FIFO depth.
package uart_pkg;

   localparam int unsigned UART_RX_FIFO_DEPTH_DEF = 16;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } rx_word_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Host-side valid/ready byte stream of the UART RX FIFO.
// The master side drives data and valid; the slave side returns ready.
interface uart_rx_fifo_if;

   logic [7:0] m_data;
   logic       m_err;
   logic       m_valid;
   logic       m_ready;

   modport master (output m_data, output m_err, output m_valid, input m_ready);
   modport slave  (input m_data, input m_err, input m_valid, output m_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO built from a flop array.
// Push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | (pop & ~empty)) & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop) begin
            count_q <= count_q + CW'(1);
         end else if (do_pop && !do_push) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: one push per rx_done rising edge, sticky overrun, valid/ready output.
// Define UART_RX_DROP_ERR_EN to discard frames received with a parity error.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned  DEPTH = UART_RX_FIFO_DEPTH_DEF,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_done,
   input  logic          rx_error,
   output logic          rx_full,
   uart_rx_fifo_if.master m,
   output logic [CW-1:0] count,
   output logic          overrun,
   input  logic          clr_overrun,
   input  logic          flush
);

   logic     done_q;
   logic     overrun_q;
   logic     frame_edge;
   logic     push_req;
   logic     pop_req;
   logic     fifo_full;
   logic     fifo_empty;
   rx_word_t wword;
   rx_word_t rword;

   // done_q resets high so a receiver already asserting rx_done cannot fake a frame edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q <= 1'b1;
      end else begin
         done_q <= rx_done;
      end
   end

   assign frame_edge = rx_done & ~done_q;
   assign wword      = '{err: rx_error, data: rx_data};
   assign pop_req    = m.m_valid & m.m_ready;

`ifdef UART_RX_DROP_ERR_EN
   logic unused_rword_err;
   assign push_req         = frame_edge & ~rx_error;
   assign m.m_err          = 1'b0;
   assign unused_rword_err = rword.err;
`else
   assign push_req = frame_edge;
   assign m.m_err  = rword.err;
`endif

   uart_sync_fifo #(
      .WIDTH ($bits(rx_word_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .wdata (wword),
      .pop   (m.m_ready),
      .flush (flush),
      .rdata (rword),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A new overrun outranks a clear in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else if (push_req && fifo_full && !pop_req) begin
         overrun_q <= 1'b1;
      end else if (clr_overrun) begin
         overrun_q <= 1'b0;
      end
   end

   assign rx_full   = fifo_full;
   assign overrun   = overrun_q;
   assign m.m_valid = ~fifo_empty;
   assign m.m_data  = rword.data;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based model of the buffer.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rx_error;
   logic       clr_overrun;
   logic       flush;
   logic       rx_full;
   logic       overrun;
   logic [4:0] count;

   int n_pass  = 0;
   int n_total = 0;

   logic [8:0] q[$];
   bit         ov_m;
   bit         done_m;

   uart_rx_fifo_if bus ();

   uart_rx_fifo #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .rx_error    (rx_error),
      .rx_full     (rx_full),
      .m           (bus.master),
      .count       (count),
      .overrun     (overrun),
      .clr_overrun (clr_overrun),
      .flush       (flush)
   );

   always #5 clk = ~clk;

   // Advance the model by the rules for one cycle, then step the DUT through one edge.
   task automatic tick();
      bit push, pop, drop;
      push = rx_done && !done_m;
`ifdef UART_RX_DROP_ERR_EN
      if (rx_error) push = 1'b0;
`endif
      pop  = bus.m_ready && (q.size() != 0);
      drop = push && (q.size() == DEPTH) && !pop;
      if (flush) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (push && !drop) q.push_back({rx_error, rx_data});
      end
      if (drop) ov_m = 1'b1;
      else if (clr_overrun) ov_m = 1'b0;
      done_m = rx_done;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic e, input int stop, input int gap);
      rx_data  = d;
      rx_error = e;
      rx_done  = 1'b1;
      repeat (stop) tick();
      rx_done  = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic drain();
      bus.m_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2 && q.size() != 0; i++) tick();
      bus.m_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_done = 1'b1; rx_data = 8'h00; rx_error = 1'b0;
      clr_overrun = 1'b0; flush = 1'b0; bus.m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      q.delete(); ov_m = 1'b0; done_m = 1'b1;
      repeat (20) tick();
      n_total++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
      n_total++; if (bus.m_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.m_valid); else n_pass++;
      n_total++; if (rx_full !== 1'b0) $display("FAIL reset_full got %b want 0", rx_full); else n_pass++;
      n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else n_pass++;
      n_total++; if ({bus.m_err, bus.m_data} !== 9'h000)
         $display("FAIL reset_head got %h want 000", {bus.m_err, bus.m_data}); else n_pass++;
   endtask

   task automatic test_single();
      rx_data = 8'hA5; rx_error = 1'b0; rx_done = 1'b0;
      tick();
      rx_done = 1'b1;
      tick();
      n_total++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA5 || bus.m_err !== 1'b0)
         $display("FAIL single_head got v=%b d=%h e=%b want v=1 d=a5 e=0",
                  bus.m_valid, bus.m_data, bus.m_err); else n_pass++;
      repeat (31) tick();
      rx_done = 1'b0;
      tick();
      n_total++; if (count !== 5'(q.size()) || count !== 5'd1)
         $display("FAIL single_count got %0d want 1", count); else n_pass++;
      drain();
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, $urandom_range(16, 32), $urandom_range(1, 4));
      n_total++; if (count !== 5'd16) $display("FAIL ovr_count got %0d want 16", count); else n_pass++;
      n_total++; if (rx_full !== 1'b1) $display("FAIL ovr_full got %b want 1", rx_full); else n_pass++;
      n_total++; if (overrun !== ov_m || !ov_m) $display("FAIL ovr_flag got %b want 1", overrun); else n_pass++;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         n_total++;
         if (bus.m_valid !== 1'b1 || bus.m_data !== 8'(i))
            $display("FAIL ovr_drain[%0d] got v=%b d=%h want v=1 d=%h", i, bus.m_valid, bus.m_data, 8'(i));
         else n_pass++;
         tick();
      end
      bus.m_ready = 1'b0;
      n_total++; if (bus.m_valid !== 1'b0) $display("FAIL ovr_extra got v=%b d=%h want v=0",
                                                    bus.m_valid, bus.m_data); else n_pass++;
   endtask

   task automatic test_full_push_pop();
      logic [7:0] last;
      last = 8'h00;
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      n_total++; if (overrun !== 1'b0) $display("FAIL fpp_clr got %b want 0", overrun); else n_pass++;
      for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 16, 1);
      rx_data = 8'h55; rx_error = 1'b0; rx_done = 1'b1; bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      repeat (15) tick();
      rx_done = 1'b0;
      tick();
      n_total++; if (overrun !== 1'b0) $display("FAIL fpp_overrun got %b want 0", overrun); else n_pass++;
      n_total++; if (count !== 5'd16) $display("FAIL fpp_count got %0d want 16", count); else n_pass++;
      bus.m_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         n_total++;
         if (q.size() == 0 || {bus.m_err, bus.m_data} !== q[0])
            $display("FAIL fpp_drain[%0d] got %h want %h", i, {bus.m_err, bus.m_data},
                     (q.size() == 0) ? 9'h000 : q[0]);
         else n_pass++;
         last = bus.m_data;
         tick();
      end
      bus.m_ready = 1'b0;
      n_total++; if (last !== 8'h55) $display("FAIL fpp_last got %h want 55", last); else n_pass++;
   endtask

   task automatic test_error();
      send_frame(8'h3C, 1'b1, 16, 2);
`ifdef UART_RX_DROP_ERR_EN
      n_total++; if (count !== 5'd0) $display("FAIL err_drop_count got %0d want 0", count); else n_pass++;
      n_total++; if (overrun !== 1'b0) $display("FAIL err_drop_ovr got %b want 0", overrun); else n_pass++;
`else
      n_total++; if (bus.m_valid !== 1'b1 || bus.m_err !== 1'b1 || bus.m_data !== 8'h3C)
         $display("FAIL err_keep got v=%b e=%b d=%h want v=1 e=1 d=3c",
                  bus.m_valid, bus.m_err, bus.m_data); else n_pass++;
`endif
      drain();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 17; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 2, 1);
      n_total++; if (overrun !== 1'b1) $display("FAIL fl_setovr got %b want 1", overrun); else n_pass++;
      drain();
      for (int i = 0; i < 5; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 3, 2);
      n_total++; if (count !== 5'd5) $display("FAIL fl_occ got %0d want 5", count); else n_pass++;
      rx_data = 8'hE7; rx_done = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0;
      n_total++; if (count !== 5'd0 || bus.m_valid !== 1'b0)
         $display("FAIL fl_empty got c=%0d v=%b want c=0 v=0", count, bus.m_valid); else n_pass++;
      n_total++; if (overrun !== 1'b1) $display("FAIL fl_keepovr got %b want 1", overrun); else n_pass++;
      rx_done = 1'b0;
      tick();
      n_total++; if (count !== 5'd0) $display("FAIL fl_late got %0d want 0", count); else n_pass++;
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      n_total++; if (overrun !== 1'b0) $display("FAIL fl_clrovr got %b want 0", overrun); else n_pass++;
   endtask

   task automatic test_random();
      int ready_div;
      for (int c = 0; c < 800; c++) begin
         ready_div = (c < 400) ? 8 : 2;
         if ($urandom_range(0, 2) == 0) begin
            rx_done = ~rx_done;
            if (rx_done) begin
               rx_data  = 8'($urandom_range(0, 255));
               rx_error = ($urandom_range(0, 3) == 0);
            end
         end
         bus.m_ready = ($urandom_range(0, ready_div - 1) == 0);
         flush       = ($urandom_range(0, 99) == 0);
         clr_overrun = ($urandom_range(0, 15) == 0);
         tick();
         n_total++;
         if ({count, bus.m_valid, rx_full, overrun} !==
             {5'(q.size()), q.size() != 0, q.size() == DEPTH, ov_m})
            $display("FAIL rnd_state[%0d] got c=%0d v=%b f=%b o=%b want c=%0d v=%b f=%b o=%b", c,
                     count, bus.m_valid, rx_full, overrun, q.size(), q.size() != 0,
                     q.size() == DEPTH, ov_m);
         else n_pass++;
         if (q.size() != 0) begin
            n_total++;
            if ({bus.m_err, bus.m_data} !== q[0])
               $display("FAIL rnd_head[%0d] got %h want %h", c, {bus.m_err, bus.m_data}, q[0]);
            else n_pass++;
         end
      end
      rx_done = 1'b0; bus.m_ready = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_overrun();
      test_full_push_pop();
      test_error();
      test_flush();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout got no finish want finish within 1ms");
      $fatal(1);
   end

endmodule
